// File: rtl/mem_d1_stream_loader.sv
// Stream-to-memory loader: latches base/count on go, then writes one accepted
// stream word per std_mem_d1 write cycle, waiting for the memory's done each time.
module mem_d1_stream_loader #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] base,
    input  logic [IDX_SIZE:0]   count,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic [WIDTH-1:0]    mem_write_data,
    output logic                mem_write_en,
    input  logic                mem_done,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_WRITE,
        S_WAIT_DONE,
        S_FINISH
    } state_e;

    localparam logic [IDX_SIZE:0]   SIZE_W   = (IDX_SIZE + 1)'(SIZE);
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

    state_e                state_q;
    logic [IDX_SIZE-1:0]   ptr_q;
    logic [IDX_SIZE:0]     rem_q;
    logic                  in_ready_q;
    logic [IDX_SIZE-1:0]   addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wen_q;
    logic                  done_q;
    logic                  err_q;

    logic                  base_oob_d;
    logic                  count_oob_d;
    logic [IDX_SIZE-1:0]   start_ptr_d;
    logic [IDX_SIZE:0]     start_rem_d;
    logic [IDX_SIZE-1:0]   ptr_inc_d;
    logic [IDX_SIZE:0]     rem_dec_d;

    // Out-of-range start arguments are clamped rather than rejected.
    always_comb begin
        base_oob_d  = {1'b0, base} >= SIZE_W;
        count_oob_d = count > SIZE_W;
        start_ptr_d = base_oob_d ? '0 : base;
        start_rem_d = count_oob_d ? SIZE_W : count;
        ptr_inc_d   = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_SIZE'(1);
        rem_dec_d   = rem_q - (IDX_SIZE + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        ptr_q <= start_ptr_d;
                        rem_q <= start_rem_d;
                        err_q <= base_oob_d | count_oob_d;
                        if (start_rem_d == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT_DATA;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (in_valid) begin
                        wdata_q    <= in_data;
                        addr_q     <= ptr_q;
                        in_ready_q <= 1'b0;
                        wen_q      <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (mem_done) begin
                        ptr_q <= ptr_inc_d;
                        rem_q <= rem_dec_d;
                        if (rem_dec_d == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT_DATA;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_addr0      = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write_en   = wen_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mem_d1_stream_loader.sv
// Bench for mem_d1_stream_loader: std_mem_d1-style memory model with adjustable
// done latency, randomized stream data, expectations from a list-level model.
module tb_mem_d1_stream_loader;

    localparam int W  = 32;
    localparam int SZ = 16;
    localparam int IX = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [IX-1:0] base;
    logic [IX:0]   count;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [IX-1:0] mem_addr0;
    logic [W-1:0]  mem_write_data;
    logic          mem_write_en;
    logic          mem_done;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    mem_d1_stream_loader #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(IX)) dut (
        .clk(clk), .reset(reset), .go(go), .base(base), .count(count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_done(mem_done),
        .done(done), .err(err)
    );

    // Memory model: write on the edge, done delayed mem_delay cycles after write_en.
    logic [W-1:0] mem [SZ];
    logic [7:0]   hist = '0;
    int           mem_delay = 1;
    logic         spur = 1'b0;

    always @(posedge clk) begin
        hist <= {hist[6:0], mem_write_en};
        if (mem_write_en && mem_addr0 < IX'(SZ)) mem[mem_addr0[3:0]] <= mem_write_data;
    end
    assign mem_done = hist[mem_delay-1] | spur;

    logic [W-1:0] model_mem [SZ];
    bit           model_written [SZ];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input int b, input int c, input int stall, input int delay,
                            input bit spurious, input bit abort, input string tag);
        int n, b0, cyc, idx, scnt, done_cyc, done_cnt, nexp;
        bit exp_err, prev_stall, finished, aborted, bad;
        logic [W-1:0]  words[$];
        logic [IX+W-1:0] obs[$];
        logic [IX+W-1:0] e;

        n       = (c > SZ) ? SZ : c;
        b0      = (b >= SZ) ? 0 : b;
        exp_err = (b >= SZ) || (c > SZ);
        for (int i = 0; i < n; i++) words.push_back($urandom);
        mem_delay = delay;

        @(negedge clk);
        go = 1'b1; base = IX'(b); count = (IX+1)'(c);
        in_valid = 1'b0; in_data = $urandom;
        @(posedge clk);
        cyc = 0; idx = 0; scnt = 0; done_cnt = 0; done_cyc = -1;
        prev_stall = 0; finished = 0; aborted = 0;

        while (!finished && cyc < 400) begin
            @(negedge clk);
            go = 1'b0;
            if (mem_write_en) obs.push_back({mem_addr0, mem_write_data});
            if (prev_stall) check({tag, "_ready_held"}, 64'(in_ready), 64'd1);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc + 1;
            end
            if (done_cyc >= 0 && cyc + 1 > done_cyc) finished = 1;

            if (abort && obs.size() == 2 && !mem_write_en && !in_ready && !done) begin
                in_valid = 1'b0;
                reset = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check({tag, "_reset_outs"},
                      64'({in_ready, mem_write_en, done, err, mem_addr0, mem_write_data}), 64'd0);
                reset = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                    if (mem_write_en) obs.push_back({mem_addr0, mem_write_data});
                end
                aborted = 1; finished = 1;
            end else begin
                prev_stall = 0;
                spur = 1'b0;
                if (idx < n && in_ready) begin
                    if (scnt < stall) begin
                        in_valid = 1'b0; in_data = $urandom;
                        scnt++; prev_stall = 1;
                        if (spurious && idx == 1 && scnt == 1) spur = 1'b1;
                    end else begin
                        in_valid = 1'b1; in_data = words[idx];
                        idx++; scnt = 0;
                    end
                end else begin
                    in_valid = 1'b0; in_data = $urandom;
                end
                @(posedge clk);
                cyc++;
            end
        end
        spur = 1'b0; in_valid = 1'b0;

        check({tag, "_terminated"}, 64'(finished), 64'd1);
        nexp = abort ? 2 : n;
        if (abort) begin
            check({tag, "_aborted"}, 64'(aborted), 64'd1);
            check({tag, "_no_done"}, 64'(done_cnt), 64'd0);
        end else begin
            check({tag, "_done_cycle"}, 64'(done_cyc), 64'(n * (3 + (delay - 1) + stall) + 1));
            check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
            check({tag, "_err"}, 64'(err), 64'(exp_err));
        end
        check({tag, "_nwrites"}, 64'(obs.size()), 64'(nexp));
        bad = 0;
        for (int i = 0; i < nexp; i++) begin
            e = {IX'((b0 + i) % SZ), words[i]};
            if (i >= obs.size() || obs[i] !== e) bad = 1;
            model_mem[(b0 + i) % SZ] = words[i];
            model_written[(b0 + i) % SZ] = 1;
        end
        check({tag, "_write_seq"}, 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < SZ; i++)
            if (model_written[i] && mem[i] !== model_mem[i]) bad = 1;
        check({tag, "_readback"}, 64'(bad), 64'd0);
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; base = '0; count = '0;
        in_data = '0; in_valid = 1'b0;
        for (int i = 0; i < SZ; i++) model_written[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 64'({in_ready, mem_write_en, done, err, mem_addr0, mem_write_data}), 64'd0);
        reset = 1'b1;

        run_xfer(2, 3, 0, 1, 0, 0, "basic");
        run_xfer(14, 4, 0, 1, 0, 0, "wrap");
        run_xfer(2, 3, 5, 1, 0, 0, "backpressure");
        run_xfer(7, 0, 0, 1, 0, 0, "zero_count");
        run_xfer(20, 17, 0, 1, 0, 0, "over_range");
        run_xfer(3, 2, 0, 1, 0, 0, "err_cleared");
        run_xfer(5, 3, 3, 4, 1, 0, "slow_spurious");
        run_xfer(0, 4, 0, 1, 0, 1, "abort");
        run_xfer(0, 1, 0, 1, 0, 0, "after_abort");
        for (int r = 0; r < 6; r++)
            run_xfer($urandom_range(0, 20), $urandom_range(0, 17), $urandom_range(0, 3),
                     $urandom_range(1, 3), 0, 0, "random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
